// File: rtl/irq_priority_arbiter.sv
// irq_priority_arbiter: shares one CPU interrupt line among NUM_SRC sources (edge-latched pending, mask,
// priority with round-robin tie-break, ack/done handshake), configured over APB. Optional macro IRQ_TIMEOUT_EN.
module irq_priority_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int IDW     = $clog2(NUM_SRC),
    parameter int TIMEOUT = 255
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [4:0]         paddr,
    input  logic [15:0]        pwdata,
    input  logic               pwrite,
    input  logic               penable,
    output logic [15:0]        prdata,
    output logic               pready,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq_valid,
    output logic [IDW-1:0]     irq_id,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic [3:0]         o_dbg_state
);

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_ARB   = 4'b0010;
    localparam logic [3:0] ST_GRANT = 4'b0100;
    localparam logic [3:0] ST_WAIT  = 4'b1000;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [PRIO_W-1:0]  r_prio [NUM_SRC];
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_irq_d;
    logic [IDW-1:0]     r_rr;
    logic [IDW-1:0]     r_irq_id;
    logic               r_pready;
    logic               r_apb_seen;
    logic [15:0]        r_prdata;

    logic               w_access;
    logic               w_wr;
    logic [15:0]        w_rdata;
    logic [NUM_SRC-1:0] w_pend_clr;
    logic [NUM_SRC-1:0] w_cand;
    logic [IDW-1:0]     w_win_id;
    logic [PRIO_W-1:0]  w_best;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_idx;
    logic [IDW-1:0]     w_id_inc;
    logic               w_in_service;
    logic               w_load_id;
    logic               w_ack_take;
    logic               w_to_fire;
    logic               w_to_hit;
    logic               w_to_flag;
    logic               w_unused;

    assign w_unused = &{1'b0, pwdata};

    // r_apb_seen blocks a second access until the master drops penable.
    assign w_access = penable & ~r_pready & ~r_apb_seen;
    assign w_wr     = w_access & pwrite;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_pready   <= 1'b0;
            r_apb_seen <= 1'b0;
            r_prdata   <= '0;
        end else begin
            r_pready   <= w_access;
            r_apb_seen <= penable & (r_apb_seen | w_access);
            r_prdata   <= (w_access && !pwrite) ? w_rdata : '0;
        end
    end

    assign pready = r_pready;
    assign prdata = r_prdata;

    always_ff @(posedge pclk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (preset) begin
                r_prio[i] <= '0;
            end else if (w_wr && paddr == 5'(i)) begin
                r_prio[i] <= pwdata[PRIO_W-1:0];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_mask <= '0;
        end else if (w_wr && paddr == 5'd16) begin
            r_mask <= pwdata[NUM_SRC-1:0];
        end
    end

    always_comb begin
        w_pend_clr = '0;
        if (w_wr && paddr == 5'd17) begin
            w_pend_clr = pwdata[NUM_SRC-1:0];
        end
        if (w_ack_take) begin
            w_pend_clr[r_irq_id] = 1'b1;
        end
    end

    // A rising edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_irq_d <= '0;
            r_pend  <= '0;
        end else begin
            r_irq_d <= irq_in;
            r_pend  <= (r_pend & ~w_pend_clr) | (irq_in & ~r_irq_d);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_cand[i] = r_pend[i] & r_mask[i] & (|r_prio[i]);
        end
    end

    // Scan upward from the RR pointer; strict '>' keeps the first source found at the top priority.
    always_comb begin
        w_win_id = '0;
        w_best   = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, r_rr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_SRC)) begin
                w_sum = w_sum - (IDW+1)'(NUM_SRC);
            end
            w_idx = w_sum[IDW-1:0];
            if (w_cand[w_idx] && r_prio[w_idx] > w_best) begin
                w_best   = r_prio[w_idx];
                w_win_id = w_idx;
            end
        end
    end

    assign w_id_inc = (r_irq_id == IDW'(NUM_SRC-1)) ? '0 : r_irq_id + IDW'(1);

`ifdef IRQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_to_flag;

    // Held at zero outside GRANT, so every GRANT entry starts a fresh count.
    always_ff @(posedge pclk) begin
        if (preset || r_state != ST_GRANT) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_to_flag <= 1'b0;
        end else if (w_to_fire) begin
            r_to_flag <= 1'b1;
        end else if (w_wr && paddr == 5'd18) begin
            r_to_flag <= 1'b0;
        end
    end

    assign w_to_hit  = (r_to_cnt == TO_W'(TIMEOUT-1));
    assign w_to_flag = r_to_flag;
`else
    assign w_to_hit  = 1'b0;
    assign w_to_flag = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|w_cand) w_state_nxt = ST_ARB;
            ST_ARB:   w_state_nxt = (|w_cand) ? ST_GRANT : ST_IDLE;
            ST_GRANT: begin
                if (irq_ack) begin
                    w_state_nxt = ST_WAIT;
                end else if (!w_cand[r_irq_id] || w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT:  if (irq_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_valid    = (r_state == ST_GRANT);
        w_in_service = (r_state == ST_WAIT);
        w_load_id    = (r_state == ST_ARB) && (|w_cand);
        w_ack_take   = (r_state == ST_GRANT) && irq_ack;
        w_to_fire    = (r_state == ST_GRANT) && !irq_ack && w_cand[r_irq_id] && w_to_hit;
        o_dbg_state  = r_state;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_irq_id <= '0;
            r_rr     <= '0;
        end else begin
            if (w_load_id) begin
                r_irq_id <= w_win_id;
            end
            if (w_ack_take || w_to_fire) begin
                r_rr <= w_id_inc;
            end
        end
    end

    assign irq_id = r_irq_id;

    always_comb begin
        w_rdata = '0;
        case (paddr)
            5'd16: w_rdata[NUM_SRC-1:0] = r_mask;
            5'd17: w_rdata[NUM_SRC-1:0] = r_pend;
            5'd18: begin
                w_rdata[15]      = irq_valid;
                w_rdata[14]      = w_in_service;
                w_rdata[13]      = w_to_flag;
                w_rdata[IDW-1:0] = r_irq_id;
            end
            default: begin
                if (paddr < 5'(NUM_SRC)) begin
                    w_rdata[PRIO_W-1:0] = r_prio[paddr[IDW-1:0]];
                end
            end
        endcase
    end

endmodule
